// File: rtl/iack_pkg.sv
// Shared types and constants for the interrupt acknowledge responder.
package iack_pkg;

  localparam int unsigned LVL_W   = 3;
  localparam int unsigned NUM_SRC = 7;

  localparam logic [7:0] AUTOVEC_BASE     = 8'h18;
  localparam logic [7:0] SPURIOUS_VEC_DEF = 8'h18;

  // state  | meaning
  // IDLE   | waiting for a qualified IACK strobe
  // ACK    | wb_ack_o asserted for this single cycle
  // WAIT   | ack given, holding until the strobe is released
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } iack_state_e;

  // Highest set pending bit as a 1-based level; 0 when nothing is pending.
  function automatic logic [LVL_W-1:0] encode_level(input logic [NUM_SRC-1:0] pend);
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend[i]) lvl = LVL_W'(i + 1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/irq_pending_latch.sv
// One interrupt source: rising-edge detect feeding a pending bit where a new
// edge beats a simultaneous acknowledge clear.
module irq_pending_latch (
  input  logic wb_clk_i,
  input  logic wb_reset_n_i,
  input  logic req,
  input  logic clr,
  output logic pending
);

  logic req_r;
  logic rise;

  assign rise = req & ~req_r;

  // Previous request sample for edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) req_r <= 1'b0;
    else               req_r <= req;
  end

  // Pending bit: set on an edge, cleared on acknowledge, set wins a tie.
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) pending <= 1'b0;
    else if (rise)     pending <= 1'b1;
    else if (clr)      pending <= 1'b0;
  end

endmodule

// File: rtl/interrupt_ack_responder.sv
// Latches peripheral interrupt edges, presents the highest pending level to
// the 68000 core and answers its IACK bus cycle with a vector or autovector.
//
// state  | meaning
// IDLE   | waiting for a qualified IACK strobe (cyc & stb & iack)
// ACK    | response registered, wb_ack_o high for exactly this cycle
// WAIT   | holding until wb_stb_i drops so a held strobe is not re-acked
module interrupt_ack_responder
  import iack_pkg::*;
#(
  parameter logic [7:0] VEC_BASE     = 8'h40,
  parameter logic [6:0] AUTOVEC_MASK = 7'h00,
  parameter logic [7:0] SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_reset_n_i,
  input  logic [6:0]       int_i,
  output logic [LVL_W-1:0] ipl_o,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             iack_i,
  input  logic [2:0]       wb_adr_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  output logic             avec_o
);

  iack_state_e        state;
  iack_state_e        state_next;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pend_clr;
  logic               load_rsp;
  logic               iack_qual;
  logic               lvl_pending;
  logic               lvl_autovec;
  logic [7:0]         pend_ext;
  logic [7:0]         mask_ext;
  logic [7:0]         lvl_sel;

  // Level 0 maps to bit 0 of the extended vectors, which is never set, so
  // adr=0 naturally falls through to the spurious response.
  assign pend_ext    = {pending, 1'b0};
  assign mask_ext    = {AUTOVEC_MASK, 1'b0};
  assign lvl_sel     = 8'd1 << wb_adr_i;
  assign lvl_pending = pend_ext[wb_adr_i];
  assign lvl_autovec = mask_ext[wb_adr_i];
  assign iack_qual   = wb_cyc_i & wb_stb_i & iack_i;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_pending_latch u_latch (
      .wb_clk_i     (wb_clk_i),
      .wb_reset_n_i (wb_reset_n_i),
      .req          (int_i[g]),
      .clr          (pend_clr[g]),
      .pending      (pending[g])
    );
  end

  // Registered priority level toward the core.
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) ipl_o <= '0;
    else               ipl_o <= encode_level(pending);
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) state <= ST_IDLE;
    else               state <= state_next;
  end

  // Next-state decode, response load strobe and pending clear.
  always_comb begin
    state_next = state;
    load_rsp   = 1'b0;
    pend_clr   = '0;
    case (state)
      ST_IDLE: begin
        if (iack_qual) begin
          load_rsp   = 1'b1;
          state_next = ST_ACK;
          if (lvl_pending) pend_clr = lvl_sel[7:1];
        end
      end
      ST_ACK:  state_next = ST_WAIT;
      ST_WAIT: if (!wb_stb_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign wb_ack_o = (state == ST_ACK);

  // Response data, held until the next IACK is decoded.
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      wb_dat_o <= 8'h00;
      avec_o   <= 1'b0;
    end else if (load_rsp) begin
      if (lvl_pending && lvl_autovec) begin
        wb_dat_o <= AUTOVEC_BASE + {5'b0, wb_adr_i};
        avec_o   <= 1'b1;
      end else if (lvl_pending) begin
        wb_dat_o <= VEC_BASE + {5'b0, wb_adr_i} - 8'd1;
        avec_o   <= 1'b0;
      end else begin
        wb_dat_o <= SPURIOUS_VEC;
        avec_o   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/interrupt_ack_responder.md
# interrupt_ack_responder

CPU-side counterpart to the interrupt controller. It latches peripheral interrupt requests as edge-triggered pending bits and drives the encoded priority level to the 68000 core. It also answers the core's interrupt-acknowledge (IACK) bus cycle on the Wishbone side with a vector number or autovector indication. The acknowledged level's pending bit is cleared so the next request can be presented.

## Interface
Parameters:
- VEC_BASE, 8'h40: user vector number for level 1; level L returns VEC_BASE+L-1.
- AUTOVEC_MASK, 7'h00: bit L-1 set means level L is answered by autovector.
- SPURIOUS_VEC, 8'h18: vector returned when the acknowledged level has nothing pending.

Ports:
- wb_clk_i, in, 1: system clock; all logic is on its rising edge.
- wb_reset_n_i, in, 1: reset, asynchronous, active-low.
- int_i, in, 7: peripheral requests; bit n is level n+1; assumed synchronous to wb_clk_i.
- ipl_o, out, 3: encoded highest pending level to the CPU core; 0 means none.
- wb_cyc_i, in, 1: Wishbone cycle.
- wb_stb_i, in, 1: Wishbone strobe.
- iack_i, in, 1: current cycle is an IACK cycle (FC=7 decode done upstream).
- wb_adr_i, in, 3: level being acknowledged (address bits 3:1).
- wb_dat_o, out, 8: vector number.
- wb_ack_o, out, 1: cycle acknowledge.
- avec_o, out, 1: autovector request to the core, valid with wb_ack_o.

## Operation
- Edge detection:
  - int_r <= int_i every clock.
  - rise[n] = int_i[n] & ~int_r[n].
  - pending[n] is set on rise[n] and cleared when level n+1 is acknowledged.
  - If set and clear hit the same bit in the same cycle, set wins.
- ipl_o is registered: index of the highest set pending bit plus 1, else 0.
- FSM states: IDLE, ACK, WAIT.
  - IDLE: when wb_cyc_i & wb_stb_i & iack_i, register the response, clear pending[L-1], go to ACK.
  - ACK: wb_ack_o=1 for exactly this one cycle; go to WAIT.
  - WAIT: hold until wb_stb_i=0, then go to IDLE. This prevents a double-ack on a held strobe.
- Response for level L = wb_adr_i:
  - L=0, or pending[L-1]=0: wb_dat_o=SPURIOUS_VEC, avec_o=0, no pending change.
  - Pending and AUTOVEC_MASK[L-1]=1: wb_dat_o=8'h18+L, avec_o=1.
  - Pending and autovector not selected: wb_dat_o=VEC_BASE+L-1, avec_o=0.
- Vector arithmetic is 8-bit and wraps modulo 256.
- Cycles with iack_i=0 are ignored: no ack, and another slave answers.
- wb_dat_o and avec_o hold their value until the next IACK response.

## Timing
- Reset values: ipl_o=0, wb_dat_o=0, wb_ack_o=0, avec_o=0, pending=0, int_r=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-cycle drops wb_ack_o immediately and loses all pending requests.
- Interrupt latency:
  - int_i rise sampled at edge N sets pending at edge N.
  - ipl_o changes at edge N+1.
- IACK latency:
  - Qualified strobe sampled at edge M gives wb_ack_o high from M to M+1.
  - The pending clear takes effect at M.
  - ipl_o reflects the clear at M+1.
- A level held high produces only one pending event. It must drop and rise again to re-request.
- While in ACK or WAIT, new interrupt edges are still latched. Only IACK decoding is blocked.

## Structure
- Shared package iack_pkg holds:
  - the state enum (IDLE/ACK/WAIT);
  - AUTOVEC_BASE = 8'h18;
  - the default SPURIOUS_VEC;
  - the level width (3) and source count (7).
- Sub-module irq_pending_latch holds per-source edge detect plus set-wins pending bit, with set/clear inputs. It is instantiated 7 times.
- The priority encoder and FSM stay in the top level.

## Test plan
- Pulse int_i[2] for 1 cycle -> ipl_o=3 two edges later. Pulse int_i[5] -> ipl_o=6. IACK at level 6 -> wb_dat_o=8'h45, then ipl_o=3.
- AUTOVEC_MASK=7'h10, pend level 5, IACK adr=5 -> avec_o=1, wb_dat_o=8'h1D, single-cycle wb_ack_o.
- IACK adr=4 with nothing pending -> wb_dat_o=8'h18, avec_o=0, pending unchanged.
- Re-assert int_i[3] in the same cycle its IACK clears it -> pending stays set, ipl_o=4.
- Hold wb_stb_i for 5 cycles -> exactly one ack. A cycle with iack_i=0 -> no ack.
- Assert wb_reset_n_i low during ACK -> wb_ack_o=0 and ipl_o=0 immediately, state IDLE.
